// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
// Owner encoding of the in-flight read and default widths.
package mem_port_arbiter_pkg;

   localparam int DEF_BITS = 16;
   localparam int STARVE_W = 4;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DATA  = 2'd2
   } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bus between the two requesters, the arbiter and the memory.
// The slave modport is the arbiter side; master is the requester/memory side.
interface mem_port_arbiter_if #(parameter int BITS = 16);

   logic            if_req;
   logic [BITS-1:0] if_addr;
   logic            if_gnt;
   logic            if_rvalid;
   logic [BITS-1:0] if_rdata;

   logic            d_req;
   logic            d_we;
   logic [BITS-1:0] d_addr;
   logic [BITS-1:0] d_wdata;
   logic            d_gnt;
   logic            d_rvalid;
   logic [BITS-1:0] d_rdata;

   logic [BITS-1:0] mem_addr;
   logic [BITS-1:0] mem_wdata;
   logic            mem_save;
   logic [BITS-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_addr, mem_wdata, mem_save
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_addr, mem_wdata, mem_save
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data path has priority, fetch is forced through after
// MAX_STARVE consecutive losses; the one in-flight read is routed back next cycle.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int BITS       = DEF_BITS,
   parameter int MAX_STARVE = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_port_arbiter_if.slave    bus
);

   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
   owner_e              pend_q, pend_d;
   logic                fetch_win, data_win;
   logic [BITS-1:0]     addr_mux, wdata_mux;

   // Grants are suppressed while reset is held so nothing reaches the memory.
   always_comb begin
      fetch_win = 1'b0;
      data_win  = 1'b0;
      if (!rst) begin
         if (bus.if_req && (!bus.d_req || starve_cnt_q == STARVE_MAX))
            fetch_win = 1'b1;
         else if (bus.d_req)
            data_win = 1'b1;
      end
   end

   always_comb begin
      addr_mux  = '0;
      wdata_mux = '0;
      if (fetch_win) begin
         addr_mux = bus.if_addr;
      end else if (data_win) begin
         addr_mux  = bus.d_addr;
         wdata_mux = bus.d_wdata;
      end
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (fetch_win)
         starve_cnt_d = '0;
      else if (bus.if_req && starve_cnt_q != STARVE_MAX)
         starve_cnt_d = starve_cnt_q + 1'b1;
   end

   always_comb begin
      pend_d = OWN_NONE;
      if (fetch_win)
         pend_d = OWN_FETCH;
      else if (data_win && !bus.d_we)
         pend_d = OWN_DATA;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_q <= '0;
         pend_q       <= OWN_NONE;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         pend_q       <= pend_d;
      end
   end

   assign bus.if_gnt    = fetch_win;
   assign bus.d_gnt     = data_win;
   assign bus.mem_addr  = addr_mux;
   assign bus.mem_wdata = wdata_mux;
   assign bus.mem_save  = data_win & bus.d_we;

   // Both read ports see the memory output; only the rvalid strobes qualify them.
   assign bus.if_rvalid = (pend_q == OWN_FETCH);
   assign bus.d_rvalid  = (pend_q == OWN_DATA);
   assign bus.if_rdata  = bus.mem_rdata;
   assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory plus a shadow copy; expected reads
// are queued when a grant is seen and matched against the rvalid of the next cycle.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   typedef struct {
      owner_e      who;
      logic [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t e;
   logic [15:0] mem     [0:255];
   logic [15:0] ref_mem [0:255];

   mem_port_arbiter_if #(.BITS(16)) bus ();

   mem_port_arbiter #(.BITS(16), .MAX_STARVE(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Synchronous single-port memory, one cycle read latency.
   always @(posedge clk) begin
      if (bus.mem_save) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr[7:0]];
   end

   task automatic set_in(input logic ir, input logic [15:0] ia, input logic dr,
                         input logic dwe, input logic [15:0] da, input logic [15:0] dwd);
      bus.if_req  = ir;
      bus.if_addr = ia;
      bus.d_req   = dr;
      bus.d_we    = dwe;
      bus.d_addr  = da;
      bus.d_wdata = dwd;
   endtask

   task automatic test_reset;
      set_in(1'b1, 16'h0002, 1'b1, 1'b1, 16'h0044, 16'h1234);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.if_gnt, bus.d_gnt, bus.mem_save, bus.if_rvalid, bus.d_rvalid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs got gnt=%b%b save=%b rv=%b%b want all 0",
                  bus.if_gnt, bus.d_gnt, bus.mem_save, bus.if_rvalid, bus.d_rvalid);
      end
      checks++;
      if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin
         errors++;
         $display("FAIL reset_mem_bus got addr=%h wdata=%h want 0000 0000", bus.mem_addr, bus.mem_wdata);
      end
      set_in(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0000);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.if_gnt !== 1'b1 || bus.d_gnt !== 1'b0 || bus.mem_addr !== 16'h0002) begin
         errors++;
         $display("FAIL reset_first_fetch got if_gnt=%b d_gnt=%b addr=%h want 1 0 0002",
                  bus.if_gnt, bus.d_gnt, bus.mem_addr);
      end
      exp_q.push_back('{OWN_FETCH, ref_mem[2]});
      @(posedge clk); #1;
      set_in(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      checks++;
      if ((bus.if_rvalid | bus.d_rvalid) !== (exp_q.size() != 0)) begin
         errors++;
         $display("FAIL reset_rvalid_presence got if=%b d=%b want pending=%0d", bus.if_rvalid, bus.d_rvalid, exp_q.size());
      end else if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (bus.if_rvalid !== (e.who == OWN_FETCH) || bus.d_rvalid !== (e.who == OWN_DATA) ||
             (e.who == OWN_FETCH ? bus.if_rdata : bus.d_rdata) !== e.data) begin
            errors++;
            $display("FAIL reset_read got rv=%b%b data=%h want owner=%0d data=%h",
                     bus.if_rvalid, bus.d_rvalid, bus.mem_rdata, e.who, e.data);
         end
      end
   endtask

   task automatic test_write_read;
      @(posedge clk); #1;
      set_in(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
      @(negedge clk);
      checks++;
      if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0 || bus.mem_save !== 1'b1 ||
          bus.mem_addr !== 16'h0010 || bus.mem_wdata !== 16'hBEEF || bus.d_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL write_grant got gnt=%b%b save=%b addr=%h wdata=%h rv=%b want 01 1 0010 beef 0",
                  bus.if_gnt, bus.d_gnt, bus.mem_save, bus.mem_addr, bus.mem_wdata, bus.d_rvalid);
      end
      ref_mem[8'h10] = 16'hBEEF;
      @(posedge clk); #1;
      set_in(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000);
      @(negedge clk);
      checks++;
      if (bus.d_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0 || bus.mem_save !== 1'b0 || bus.d_gnt !== 1'b1) begin
         errors++;
         $display("FAIL write_no_rvalid got rv=%b%b save=%b d_gnt=%b want 00 0 1",
                  bus.if_rvalid, bus.d_rvalid, bus.mem_save, bus.d_gnt);
      end
      exp_q.push_back('{OWN_DATA, ref_mem[8'h10]});
      @(posedge clk); #1;
      set_in(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      checks++;
      if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL raw_read got d_rvalid=%b d_rdata=%h want 1 beef", bus.d_rvalid, bus.d_rdata);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (bus.d_rdata !== e.data || bus.if_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL raw_scoreboard got data=%h if_rvalid=%b want %h 0", bus.d_rdata, bus.if_rvalid, e.data);
         end
      end
   endtask

   task automatic test_starvation;
      logic fetch_exp;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         set_in(1'b1, 16'h0004, 1'b1, 1'b0, 16'h0030, 16'h0000);
         @(negedge clk);
         checks++;
         if ((bus.if_rvalid | bus.d_rvalid) !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL starve_rvalid_presence cyc=%0d got rv=%b%b want pending=%0d", i, bus.if_rvalid, bus.d_rvalid, exp_q.size());
         end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.if_rvalid !== (e.who == OWN_FETCH) || bus.d_rvalid !== (e.who == OWN_DATA) ||
                (e.who == OWN_FETCH ? bus.if_rdata : bus.d_rdata) !== e.data) begin
               errors++;
               $display("FAIL starve_read cyc=%0d got rv=%b%b data=%h want owner=%0d data=%h",
                        i, bus.if_rvalid, bus.d_rvalid, bus.mem_rdata, e.who, e.data);
            end
         end
         fetch_exp = ((i % 4) == 3);
         checks++;
         if (bus.if_gnt !== fetch_exp || bus.d_gnt !== !fetch_exp) begin
            errors++;
            $display("FAIL starve_pattern cyc=%0d got if_gnt=%b d_gnt=%b want %b %b", i, bus.if_gnt, bus.d_gnt, fetch_exp, !fetch_exp);
         end
         checks++;
         if (dut.starve_cnt_q !== 4'(i % 4)) begin
            errors++;
            $display("FAIL starve_cnt cyc=%0d got %0d want %0d", i, dut.starve_cnt_q, i % 4);
         end
         if (fetch_exp) exp_q.push_back('{OWN_FETCH, ref_mem[8'h04]});
         else           exp_q.push_back('{OWN_DATA,  ref_mem[8'h30]});
      end
   endtask

   task automatic test_interleave;
      logic is_fetch;
      for (int i = 0; i < 9; i++) begin
         is_fetch = (i % 2) == 0;
         @(posedge clk); #1;
         if (i == 8) set_in(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
         else        set_in(is_fetch, 16'h0000, !is_fetch, 1'b0, 16'h0020, 16'h0000);
         @(negedge clk);
         checks++;
         if ((bus.if_rvalid | bus.d_rvalid) !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL inter_rvalid_presence cyc=%0d got rv=%b%b want pending=%0d", i, bus.if_rvalid, bus.d_rvalid, exp_q.size());
         end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.if_rvalid !== (e.who == OWN_FETCH) || bus.d_rvalid !== (e.who == OWN_DATA) ||
                (e.who == OWN_FETCH ? bus.if_rdata : bus.d_rdata) !== e.data) begin
               errors++;
               $display("FAIL inter_read cyc=%0d got rv=%b%b data=%h want owner=%0d data=%h",
                        i, bus.if_rvalid, bus.d_rvalid, bus.mem_rdata, e.who, e.data);
            end
         end
         if (i < 8) begin
            checks++;
            if (bus.if_gnt !== is_fetch || bus.d_gnt !== !is_fetch ||
                bus.mem_addr !== (is_fetch ? 16'h0000 : 16'h0020)) begin
               errors++;
               $display("FAIL inter_grant cyc=%0d got gnt=%b%b addr=%h want fetch=%b", i, bus.if_gnt, bus.d_gnt, bus.mem_addr, is_fetch);
            end
            if (is_fetch) exp_q.push_back('{OWN_FETCH, ref_mem[8'h00]});
            else          exp_q.push_back('{OWN_DATA,  ref_mem[8'h20]});
         end
      end
   endtask

   task automatic test_midflight_reset;
      @(posedge clk); #1;
      set_in(1'b1, 16'h0006, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      checks++;
      if (bus.if_gnt !== 1'b1) begin
         errors++;
         $display("FAIL mid_fetch_grant got %b want 1", bus.if_gnt);
      end
      @(posedge clk); #1;
      set_in(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_drop got rv=%b%b want 00", bus.if_rvalid, bus.d_rvalid);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_after_release cyc=%0d got rv=%b%b want 00", i, bus.if_rvalid, bus.d_rvalid);
         end
      end
      @(posedge clk); #1;
      set_in(1'b1, 16'h0008, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      exp_q.push_back('{OWN_FETCH, ref_mem[8'h08]});
      @(posedge clk); #1;
      set_in(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      checks++;
      if (bus.if_rvalid !== 1'b1 || exp_q.size() == 0) begin
         errors++;
         $display("FAIL mid_reissue_rvalid got %b want 1", bus.if_rvalid);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (bus.if_rdata !== e.data) begin
            errors++;
            $display("FAIL mid_reissue_data got %h want %h", bus.if_rdata, e.data);
         end
      end
   endtask

   task automatic test_idle;
      @(posedge clk); #1;
      set_in(1'b1, 16'h000A, 1'b1, 1'b0, 16'h0040, 16'h0000);
      @(negedge clk);
      exp_q.push_back('{OWN_DATA, ref_mem[8'h40]});
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         set_in(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== e.data) begin
               errors++;
               $display("FAIL idle_lead_read got rv=%b data=%h want 1 %h", bus.d_rvalid, bus.d_rdata, e.data);
            end
         end
         checks++;
         if (bus.mem_addr !== 16'h0 || bus.mem_save !== 1'b0 || bus.if_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin
            errors++;
            $display("FAIL idle_bus cyc=%0d got addr=%h save=%b gnt=%b%b want 0000 0 00",
                     i, bus.mem_addr, bus.mem_save, bus.if_gnt, bus.d_gnt);
         end
      end
      checks++;
      if (dut.starve_cnt_q !== 4'd1) begin
         errors++;
         $display("FAIL idle_starve_hold got %0d want 1", dut.starve_cnt_q);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 16'(i * 3) ^ 16'h5A00;
         ref_mem[i] = 16'(i * 3) ^ 16'h5A00;
      end
      set_in(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      test_reset;
      test_write_read;
      test_starvation;
      test_interleave;
      test_midflight_reset;
      test_idle;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d outstanding want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout got no finish want finish before 50000");
      $fatal(1);
   end

endmodule
